// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read, writeback and reservation signals of the scoreboarded register file
interface regfile_scoreboard_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic [AW-1:0]   read_reg1;
    logic [AW-1:0]   read_reg2;
    logic [XLEN-1:0] read_data1;
    logic [XLEN-1:0] read_data2;
    logic            busy1;
    logic            busy2;
    logic [AW-1:0]   write_reg;
    logic [XLEN-1:0] write_data;
    logic            reg_write_en;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic [AW:0]     busy_count;

    modport master (
        output read_reg1, read_reg2, write_reg, write_data, reg_write_en, issue_valid, issue_rd,
        input  read_data1, read_data2, busy1, busy2, issue_ready, busy_count
    );

    modport slave (
        input  read_reg1, read_reg2, write_reg, write_data, reg_write_en, issue_valid, issue_rd,
        output read_data1, read_data2, busy1, busy2, issue_ready, busy_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: two-read one-write register file with per-register pending bits and WAW-blocking issue
module regfile_scoreboard #(
    parameter int XLEN   = 64,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input logic clk,
    input logic rst,
    regfile_scoreboard_if.slave bus
);
    localparam int NREGS = 2 ** AW;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [AW:0]      busy_count;
    logic [AW:0]      cnt_next;
    logic             wr;
    logic             fwd;
    logic             set;

    // A writeback in flight counts as already retired only when forwarding is enabled
    function automatic logic beff(input logic [AW-1:0] r);
        return busy[r] && !(fwd && bus.write_reg == r);
    endfunction

    assign wr  = bus.reg_write_en && bus.write_reg != '0;
    assign fwd = BYPASS != 0 && wr;
    assign set = bus.issue_valid && bus.issue_ready && bus.issue_rd != '0;

    assign bus.read_data1  = (fwd && bus.write_reg == bus.read_reg1) ? bus.write_data : regs[bus.read_reg1];
    assign bus.read_data2  = (fwd && bus.write_reg == bus.read_reg2) ? bus.write_data : regs[bus.read_reg2];
    assign bus.busy1       = beff(bus.read_reg1);
    assign bus.busy2       = beff(bus.read_reg2);
    assign bus.issue_ready = !beff(bus.issue_rd);
    assign bus.busy_count  = busy_count;

    // Next busy vector (set beats clear on the same register) and its population count
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wr) clr_mask[bus.write_reg] = 1'b1;
        if (set) set_mask[bus.issue_rd] = 1'b1;
        busy_next = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
        cnt_next = '0;
        for (int i = 0; i < NREGS; i++) cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
    end

    // Register storage, busy bits and registered count; register 0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr) regs[bus.write_reg] <= bus.write_data;
            busy       <= busy_next;
            busy_count <= cnt_next;
        end
    end
endmodule
